// File: rtl/seg7_pkg.sv
// Shared types, segment table and sizing helper for the multiplexed seven-segment scanner.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int SEG_W = 7;

    // Segment patterns for hex digits 0..F, bit0 = a .. bit6 = g, 1 = lit.
    localparam logic [SEG_W-1:0] SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Bits needed to hold a counter/index ranging over 0..n-1.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] segments
);

    assign segments = SEG7_HEX[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: blank/show per digit, PWM brightness inside each dwell,
// and a double-buffered digit frame that only swaps in at the digit-0 boundary.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [3:0]              brightness,
    output logic [SEG_W-1:0]        seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int IDX_W   = cnt_width(NUM_DIGITS);
    localparam int LIT_STEP = DWELL_CYCLES / 16;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};

    scan_state_t             state_r;
    scan_state_t             state_next_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_next_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_next_s;
    logic                    frame_wrap_s;

    logic [4*NUM_DIGITS-1:0] active_data_r;
    logic [NUM_DIGITS-1:0]   active_dp_r;
    logic [4*NUM_DIGITS-1:0] pending_data_r;
    logic [NUM_DIGITS-1:0]   pending_dp_r;
    logic                    pending_full_r;
    logic                    load_ready_r;
    logic                    commit_s;
    logic                    accept_s;

    logic [31:0]             lit_limit_s;
    logic                    lit_s;
    logic [3:0]              nibble_s;
    logic [SEG_W-1:0]        decoded_s;
    logic [SEG_W-1:0]        seg_next_s;
    logic                    dp_next_s;
    logic [NUM_DIGITS-1:0]   sel_next_s;

    logic [SEG_W-1:0]        seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   sel_r;
    logic                    frame_done_r;

    // Scan state, digit index and phase counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; dropping en always returns to a cleared IDLE.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        cnt_next_s   = cnt_r;
        frame_wrap_s = 1'b0;
        if (!en) begin
            state_next_s = IDLE;
            idx_next_s   = IDX_ZERO;
            cnt_next_s   = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s = BLANK;
                    idx_next_s   = IDX_ZERO;
                    cnt_next_s   = CNT_ZERO;
                end
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_next_s = SHOW;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                SHOW: begin
                    if (cnt_r == DWELL_LAST) begin
                        state_next_s = BLANK;
                        cnt_next_s   = CNT_ZERO;
                        if (idx_r == IDX_LAST) begin
                            idx_next_s   = IDX_ZERO;
                            frame_wrap_s = 1'b1;
                        end else begin
                            idx_next_s = idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    idx_next_s   = IDX_ZERO;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Commit looks only at the pre-cycle pending flag, so it never overlaps an accept.
    assign commit_s = pending_full_r && (state_next_s == BLANK) && (state_r != BLANK)
                      && (idx_next_s == IDX_ZERO);
    assign accept_s = load_valid && !pending_full_r;

    // Pending/active frame buffers and the ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_data_r  <= '0;
            active_dp_r    <= '0;
            pending_data_r <= '0;
            pending_dp_r   <= '0;
            pending_full_r <= 1'b0;
            load_ready_r   <= 1'b1;
        end else if (commit_s) begin
            active_data_r  <= pending_data_r;
            active_dp_r    <= pending_dp_r;
            pending_full_r <= 1'b0;
            load_ready_r   <= 1'b1;
        end else if (accept_s) begin
            pending_data_r <= load_data;
            pending_dp_r   <= load_dp;
            pending_full_r <= 1'b1;
            load_ready_r   <= 1'b0;
        end else begin
            pending_full_r <= pending_full_r;
            load_ready_r   <= !pending_full_r;
        end
    end

    // Outputs are computed from next-cycle state so the registered pins line up with the FSM.
    assign lit_limit_s = (32'(brightness) + 32'd1) * 32'(LIT_STEP);
    assign lit_s       = (32'(cnt_next_s) < lit_limit_s);
    assign nibble_s    = active_data_r[4*idx_next_s +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble   (nibble_s),
        .segments (decoded_s)
    );

    // Output decode: digit select during SHOW, segments only inside the PWM on-window.
    always_comb begin
        seg_next_s = '0;
        dp_next_s  = 1'b0;
        sel_next_s = '0;
        if (state_next_s == SHOW) begin
            sel_next_s[idx_next_s] = 1'b1;
            if (lit_s) begin
                seg_next_s = decoded_s;
                dp_next_s  = active_dp_r[idx_next_s];
            end else begin
                seg_next_s = '0;
                dp_next_s  = 1'b0;
            end
        end else begin
            sel_next_s = '0;
        end
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r        <= '0;
            dp_r         <= 1'b0;
            sel_r        <= '0;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_next_s;
            dp_r         <= dp_next_s;
            sel_r        <= sel_next_s;
            frame_done_r <= frame_wrap_s;
        end
    end

    assign seg_out    = seg_r;
    assign dp_out     = dp_r;
    assign digit_sel  = sel_r;
    assign frame_done = frame_done_r;
    assign load_ready = load_ready_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 32-cycle dwell and 4-cycle blanking.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          load_valid;
    logic          load_ready;
    logic [4*ND-1:0] load_data;
    logic [ND-1:0] load_dp;
    logic [3:0]    brightness;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [ND-1:0] digit_sel;
    logic          frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .brightness (brightness),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load_valid = 1'b0; load_data = '0; load_dp = '0;
        brightness = 4'd15;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        load_valid = 1'b1; load_data = d; load_dp = p;
        tick();
        load_valid = 1'b0;
    endtask

    // Raise en; sample 1 is the first BLANK cycle of digit 0.
    task automatic start_scan();
        en = 1'b1;
        tick();
        cyc = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load_valid = 1'b0; load_data = '0; load_dp = '0;
        brightness = 4'd15;
        tick(); tick();
        n_cmp++;
        if (seg_out !== 7'h00 || dp_out !== 1'b0 || digit_sel !== 4'b0000 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got seg=%h dp=%b sel=%b fd=%b exp all 0", seg_out, dp_out, digit_sel, frame_done);
        end
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b exp 1", load_ready);
        end
        rst = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_scan_order();
        logic [6:0] exp_seg [4];
        logic [6:0] eseg;
        logic [3:0] esel;
        int ph, d;
        exp_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        do_reset();
        load(16'h1234, 4'b0000);
        n_cmp++;
        if (load_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL scan_ready_after_load got %b exp 0", load_ready);
        end
        start_scan();
        n_cmp++;
        if (digit_sel !== 4'b0000 || seg_out !== 7'h00) begin
            n_bad++;
            $display("FAIL scan_first_blank got sel=%b seg=%h exp 0000/00", digit_sel, seg_out);
        end
        for (int k = 2; k <= 144; k++) begin
            tick();
            ph = (k - 1) % 36;
            d  = (k - 1) / 36;
            if (ph < 4) begin
                esel = 4'b0000; eseg = 7'h00;
            end else begin
                esel = 4'b0001 << d; eseg = exp_seg[d];
            end
            n_cmp++;
            if (digit_sel !== esel || seg_out !== eseg || dp_out !== 1'b0 || frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL scan_cycle k=%0d got sel=%b seg=%h dp=%b fd=%b exp sel=%b seg=%h dp=0 fd=0",
                         k, digit_sel, seg_out, dp_out, frame_done, esel, eseg);
            end
        end
        tick();
        n_cmp++;
        if (frame_done !== 1'b1 || digit_sel !== 4'b0000) begin
            n_bad++;
            $display("FAIL scan_frame_done_145 got fd=%b sel=%b exp 1/0000", frame_done, digit_sel);
        end
        tick();
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL scan_frame_done_146 got %b exp 0", frame_done);
        end
        run_to(288);
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL scan_frame_done_288 got %b exp 0", frame_done);
        end
        tick();
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL scan_frame_done_289 got %b exp 1", frame_done);
        end
    endtask

    task automatic test_brightness();
        logic [6:0] eseg;
        do_reset();
        load(16'h8888, 4'b0000);
        brightness = 4'd3;
        start_scan();
        run_to(4);
        for (int i = 0; i < 32; i++) begin
            tick();
            eseg = (i < 8) ? 7'h7F : 7'h00;
            n_cmp++;
            if (seg_out !== eseg || digit_sel !== 4'b0001) begin
                n_bad++;
                $display("FAIL bright3 i=%0d got seg=%h sel=%b exp seg=%h sel=0001", i, seg_out, digit_sel, eseg);
            end
        end
        brightness = 4'd0;
        run_to(40);
        for (int i = 0; i < 32; i++) begin
            tick();
            eseg = (i < 2) ? 7'h7F : 7'h00;
            n_cmp++;
            if (seg_out !== eseg || digit_sel !== 4'b0010) begin
                n_bad++;
                $display("FAIL bright0 i=%0d got seg=%h sel=%b exp seg=%h sel=0010", i, seg_out, digit_sel, eseg);
            end
        end
    endtask

    task automatic test_double_buffer();
        do_reset();
        load(16'h1111, 4'b0000);
        start_scan();
        run_to(50);
        load(16'hAAAA, 4'b0101);
        n_cmp++;
        if (load_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL dbuf_ready_after_accept got %b exp 0", load_ready);
        end
        load(16'h5555, 4'b1111);
        n_cmp++;
        if (load_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL dbuf_ready_while_full got %b exp 0", load_ready);
        end
        run_to(77);
        n_cmp++;
        if (seg_out !== 7'h06 || dp_out !== 1'b0 || digit_sel !== 4'b0100) begin
            n_bad++;
            $display("FAIL dbuf_no_tear got seg=%h dp=%b sel=%b exp 06/0/0100", seg_out, dp_out, digit_sel);
        end
        run_to(144);
        n_cmp++;
        if (seg_out !== 7'h06 || load_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL dbuf_last_old got seg=%h rdy=%b exp 06/0", seg_out, load_ready);
        end
        tick();
        n_cmp++;
        if (load_ready !== 1'b1 || frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL dbuf_commit got rdy=%b fd=%b exp 1/1", load_ready, frame_done);
        end
        run_to(149);
        n_cmp++;
        if (seg_out !== 7'h77 || dp_out !== 1'b1 || digit_sel !== 4'b0001) begin
            n_bad++;
            $display("FAIL dbuf_new_d0 got seg=%h dp=%b sel=%b exp 77/1/0001", seg_out, dp_out, digit_sel);
        end
        run_to(185);
        n_cmp++;
        if (seg_out !== 7'h77 || dp_out !== 1'b0 || digit_sel !== 4'b0010) begin
            n_bad++;
            $display("FAIL dbuf_new_d1 got seg=%h dp=%b sel=%b exp 77/0/0010", seg_out, dp_out, digit_sel);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load(16'h1111, 4'b0000);
        start_scan();
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready_after_first_commit got %b exp 1", load_ready);
        end
        run_to(144);
        load_valid = 1'b1; load_data = 16'h2222; load_dp = 4'b0000;
        tick();
        load_valid = 1'b0;
        n_cmp++;
        if (load_ready !== 1'b0 || frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept_on_commit got rdy=%b fd=%b exp 0/1", load_ready, frame_done);
        end
        run_to(149);
        n_cmp++;
        if (seg_out !== 7'h06) begin
            n_bad++;
            $display("FAIL b2b_frame2_old got seg=%h exp 06", seg_out);
        end
        run_to(257);
        n_cmp++;
        if (seg_out !== 7'h06 || digit_sel !== 4'b1000) begin
            n_bad++;
            $display("FAIL b2b_frame2_d3 got seg=%h sel=%b exp 06/1000", seg_out, digit_sel);
        end
        run_to(289);
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second_commit got rdy=%b exp 1", load_ready);
        end
        run_to(293);
        n_cmp++;
        if (seg_out !== 7'h5B || digit_sel !== 4'b0001) begin
            n_bad++;
            $display("FAIL b2b_frame3_new got seg=%h sel=%b exp 5B/0001", seg_out, digit_sel);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        load(16'h1234, 4'b0000);
        start_scan();
        run_to(82);
        n_cmp++;
        if (digit_sel !== 4'b0100 || seg_out !== 7'h5B) begin
            n_bad++;
            $display("FAIL en_before_drop got sel=%b seg=%h exp 0100/5B", digit_sel, seg_out);
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if (digit_sel !== 4'b0000 || seg_out !== 7'h00 || dp_out !== 1'b0 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL en_drop_blank got sel=%b seg=%h dp=%b fd=%b exp all 0", digit_sel, seg_out, dp_out, frame_done);
        end
        tick(); tick();
        n_cmp++;
        if (digit_sel !== 4'b0000 || seg_out !== 7'h00) begin
            n_bad++;
            $display("FAIL en_idle_hold got sel=%b seg=%h exp 0000/00", digit_sel, seg_out);
        end
        start_scan();
        n_cmp++;
        if (digit_sel !== 4'b0000 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL en_restart_blank got sel=%b fd=%b exp 0000/0", digit_sel, frame_done);
        end
        for (int k = 2; k <= 144; k++) begin
            tick();
            n_cmp++;
            if (frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL en_no_frame_done k=%0d got %b exp 0", k, frame_done);
            end
            if (k == 5) begin
                n_cmp++;
                if (digit_sel !== 4'b0001 || seg_out !== 7'h66) begin
                    n_bad++;
                    $display("FAIL en_restart_d0 got sel=%b seg=%h exp 0001/66", digit_sel, seg_out);
                end
            end
        end
        tick();
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL en_second_frame_done got %b exp 1", frame_done);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        load(16'h1111, 4'b0000);
        start_scan();
        run_to(50);
        load(16'h2222, 4'b1111);
        run_to(60);
        rst = 1'b1;
        tick();
        n_cmp++;
        if (digit_sel !== 4'b0000 || seg_out !== 7'h00 || dp_out !== 1'b0 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs got sel=%b seg=%h dp=%b fd=%b exp all 0", digit_sel, seg_out, dp_out, frame_done);
        end
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_ready got %b exp 1", load_ready);
        end
        rst = 1'b0; en = 1'b0;
        tick();
        start_scan();
        run_to(5);
        n_cmp++;
        if (seg_out !== 7'h3F || dp_out !== 1'b0 || digit_sel !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_discard_d0 got seg=%h dp=%b sel=%b exp 3F/0/0001", seg_out, dp_out, digit_sel);
        end
        run_to(41);
        n_cmp++;
        if (seg_out !== 7'h3F || digit_sel !== 4'b0010) begin
            n_bad++;
            $display("FAIL rst_discard_d1 got seg=%h sel=%b exp 3F/0010", seg_out, digit_sel);
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_brightness();
        test_double_buffer();
        test_back_to_back();
        test_enable_drop();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
